reg_spill_engine: RTL and testbench

Context save/restore engine for the 8-bit core's register file. On `start_save` it walks the register file's read port, copying every register plus the packed flag word (shift-carry, negative, zero) into data memory at a fixed base address. On `start_restore` it reads the image back and drives the register file's write port, reloading all registers and flags. It sits beside the register file and data memory, owns both ports while `busy`, and is used for interrupt entry/exit and task switching.

---
 rtl/reg_spill_engine_if.sv | 49 ++++
 rtl/reg_spill_engine.sv | 125 ++++++++++++
 tb/tb_reg_spill_engine.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_spill_engine_if.sv
// Bus bundle between the context spill engine and its register file / data memory.
// The engine takes the slave view; the surrounding system (or a bench) takes the master view.
interface reg_spill_engine_if #(
    parameter int pw = 3,
    parameter int aw = 8
);
    logic          start_save;
    logic          start_restore;
    logic          busy;
    logic          done;

    logic [pw-1:0] rf_readAddr;
    logic [7:0]    rf_dataOut;
    logic          rf_scryOut;
    logic          rf_ngtvOut;
    logic          rf_zeroOut;

    logic          rf_writeEnable;
    logic [pw-1:0] rf_writeAddr;
    logic [7:0]    rf_dataIn;
    logic          rf_scryIn;
    logic          rf_ngtvIn;
    logic          rf_zeroIn;

    logic [aw-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    modport slave (
        input  start_save, start_restore,
        output busy, done,
        output rf_readAddr,
        input  rf_dataOut, rf_scryOut, rf_ngtvOut, rf_zeroOut,
        output rf_writeEnable, rf_writeAddr, rf_dataIn, rf_scryIn, rf_ngtvIn, rf_zeroIn,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output start_save, start_restore,
        input  busy, done,
        input  rf_readAddr,
        output rf_dataOut, rf_scryOut, rf_ngtvOut, rf_zeroOut,
        input  rf_writeEnable, rf_writeAddr, rf_dataIn, rf_scryIn, rf_ngtvIn, rf_zeroIn,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/reg_spill_engine.sv
// Context save/restore engine: copies all registers plus the packed flag word to a
// fixed memory image and reloads them. Strobes decode from registered state and idx.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// S_IDLE       | waiting for start_save / start_restore (save has priority)
// S_SAVE_REGS  | write register idx to BASE+idx, one per cycle
// S_SAVE_FLAGS | write {5'b0, scry, ngtv, zero} to BASE+2**pw
// S_REST_FLAGS | read flag word into fhold, clear idx
// S_REST_REGS  | reload register idx from BASE+idx, flags from fhold
// S_DONE       | one-cycle done pulse, back to idle
module reg_spill_engine #(
    parameter int            pw   = 3,
    parameter int            aw   = 8,
    parameter logic [aw-1:0] BASE = 8'hF0
) (
    input logic               clk,
    input logic               reset,
    reg_spill_engine_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE_REGS,
        S_SAVE_FLAGS,
        S_REST_FLAGS,
        S_REST_REGS,
        S_DONE
    } state_t;

    localparam logic [pw-1:0] IDX_LAST  = {pw{1'b1}};
    localparam logic [aw-1:0] FLAG_ADDR = BASE + aw'(2**pw);

    state_t        state_q, state_d;
    logic [pw-1:0] idx_q, idx_d;
    logic [2:0]    fhold_q, fhold_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fhold_d = fhold_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_save) begin
                    state_d = S_SAVE_REGS;
                    idx_d   = '0;
                end else if (bus.start_restore) begin
                    state_d = S_REST_FLAGS;
                end
            end
            S_SAVE_REGS: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) state_d = S_SAVE_FLAGS;
            end
            S_SAVE_FLAGS: state_d = S_DONE;
            S_REST_FLAGS: begin
                fhold_d = bus.mem_rdata[2:0];
                idx_d   = '0;
                state_d = S_REST_REGS;
            end
            S_REST_REGS: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Reset aborts in place; whatever image or registers were already written stay written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            fhold_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fhold_q <= fhold_d;
        end
    end

    always_comb begin
        bus.busy           = (state_q != S_IDLE);
        bus.done           = (state_q == S_DONE);
        bus.rf_readAddr    = '0;
        bus.rf_writeEnable = 1'b0;
        bus.rf_writeAddr   = '0;
        bus.rf_dataIn      = '0;
        bus.rf_scryIn      = 1'b0;
        bus.rf_ngtvIn      = 1'b0;
        bus.rf_zeroIn      = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_we         = 1'b0;
        bus.mem_wdata      = '0;
        case (state_q)
            S_SAVE_REGS: begin
                bus.rf_readAddr = idx_q;
                bus.mem_addr    = BASE + aw'(idx_q);
                bus.mem_wdata   = bus.rf_dataOut;
                bus.mem_we      = 1'b1;
            end
            S_SAVE_FLAGS: begin
                bus.mem_addr  = FLAG_ADDR;
                bus.mem_wdata = {5'b0, bus.rf_scryOut, bus.rf_ngtvOut, bus.rf_zeroOut};
                bus.mem_we    = 1'b1;
            end
            S_REST_FLAGS: begin
                bus.mem_addr = FLAG_ADDR;
            end
            S_REST_REGS: begin
                // Every register write re-asserts the saved flags.
                bus.mem_addr       = BASE + aw'(idx_q);
                bus.rf_writeAddr   = idx_q;
                bus.rf_dataIn      = bus.mem_rdata;
                bus.rf_writeEnable = 1'b1;
                bus.rf_scryIn      = fhold_q[2];
                bus.rf_ngtvIn      = fhold_q[1];
                bus.rf_zeroIn      = fhold_q[0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_spill_engine.sv
// Bench for reg_spill_engine: register file and data memory models, directed and
// random save/restore sequences checked against an image-level reference.
module tb_reg_spill_engine;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_spill_engine_if #(.pw(3), .aw(8)) bus ();
    reg_spill_engine_if #(.pw(3), .aw(8)) bus2 ();

    reg_spill_engine #(.pw(3), .aw(8), .BASE(8'hF0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    reg_spill_engine #(.pw(3), .aw(8), .BASE(8'hFC)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    logic [7:0] mem [256];
    logic [7:0] rf  [8];
    logic       f_s, f_n, f_z;

    assign bus.rf_dataOut = rf[bus.rf_readAddr];
    assign bus.rf_scryOut = f_s;
    assign bus.rf_ngtvOut = f_n;
    assign bus.rf_zeroOut = f_z;
    assign bus.mem_rdata  = mem[bus.mem_addr];

    assign bus2.rf_dataOut = 8'h00;
    assign bus2.rf_scryOut = 1'b0;
    assign bus2.rf_ngtvOut = 1'b0;
    assign bus2.rf_zeroOut = 1'b0;
    assign bus2.mem_rdata  = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc, we_cnt, rfwe_cnt, busy_cnt, done_cyc, flag_bad;
    logic [2:0] exp_flags;
    logic [7:0] wr_addr[$];
    logic [7:0] wr_addr2[$];

    logic [7:0] orig_rf [8];
    logic [2:0] orig_fl;
    logic [7:0] img [9];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observe one cycle at the falling edge, then apply its writes to the models after the rising edge.
    task automatic tick();
        logic       do_mw, do_rw;
        logic [7:0] ma, md, rd;
        logic [2:0] ra, rfl;
        @(negedge clk);
        cyc++;
        do_mw = bus.mem_we;
        ma    = bus.mem_addr;
        md    = bus.mem_wdata;
        do_rw = bus.rf_writeEnable;
        ra    = bus.rf_writeAddr;
        rd    = bus.rf_dataIn;
        rfl   = {bus.rf_scryIn, bus.rf_ngtvIn, bus.rf_zeroIn};
        if (do_mw) begin
            we_cnt++;
            wr_addr.push_back(ma);
        end
        if (do_rw) begin
            rfwe_cnt++;
            if (rfl != exp_flags) flag_bad++;
        end
        if (bus.busy) busy_cnt++;
        if (bus.done && done_cyc < 0) done_cyc = cyc;
        if (bus2.mem_we) wr_addr2.push_back(bus2.mem_addr);
        @(posedge clk);
        if (do_mw) mem[ma] = md;
        if (do_rw) begin
            rf[ra] = rd;
            {f_s, f_n, f_z} = rfl;
        end
        #1;
    endtask

    task automatic clear_stats();
        cyc = -1; we_cnt = 0; rfwe_cnt = 0; busy_cnt = 0; done_cyc = -1; flag_bad = 0;
        wr_addr.delete();
        wr_addr2.delete();
    endtask

    task automatic run_op(input logic s, input logic r, input logic pulse_busy);
        clear_stats();
        bus.start_save    = s;
        bus.start_restore = r;
        tick();
        bus.start_save    = 1'b0;
        bus.start_restore = 1'b0;
        while (done_cyc < 0 && cyc < 40) begin
            if (pulse_busy && cyc == 3) begin
                bus.start_save    = 1'b1;
                bus.start_restore = 1'b1;
            end
            tick();
            bus.start_save    = 1'b0;
            bus.start_restore = 1'b0;
        end
        tick();
        tick();
        check("done_cycle", done_cyc, 10);
        check("busy_cycles", busy_cnt, 10);
    endtask

    task automatic set_random_rf();
        for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
        {f_s, f_n, f_z} = 3'($urandom);
    endtask

    initial begin
        reset              = 1'b0;
        bus.start_save     = 1'b0;
        bus.start_restore  = 1'b0;
        bus2.start_save    = 1'b0;
        bus2.start_restore = 1'b0;
        exp_flags          = 3'b000;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        {f_s, f_n, f_z} = 3'b000;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_rf_we", bus.rf_writeEnable, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_busy_wrap", bus2.busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Directed save
        for (int i = 0; i < 8; i++) rf[i] = 8'h10 + 8'(i);
        {f_s, f_n, f_z} = 3'b101;
        run_op(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) check($sformatf("save_mem_%0d", i), mem[8'hF0 + 8'(i)], 8'h10 + 8'(i));
        check("save_flag_word", mem[8'hF8], 8'h05);
        check("save_we_cnt", we_cnt, 9);
        check("save_rf_we_cnt", rfwe_cnt, 0);
        for (int i = 0; i < 9; i++)
            check($sformatf("save_addr_%0d", i), (i < wr_addr.size()) ? wr_addr[i] : 8'hxx, 8'hF0 + 8'(i));

        // Directed restore
        for (int i = 0; i < 8; i++) mem[8'hF0 + 8'(i)] = 8'hA0 + 8'(i);
        mem[8'hF8] = 8'hFA;
        exp_flags  = 3'b010;
        run_op(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) check($sformatf("rest_rf_%0d", i), rf[i], 8'hA0 + 8'(i));
        check("rest_flags", {f_s, f_n, f_z}, 3'b010);
        check("rest_flag_strobes", flag_bad, 0);
        check("rest_rf_we_cnt", rfwe_cnt, 8);
        check("rest_mem_we_cnt", we_cnt, 0);

        // Both starts together, plus starts pulsed while busy: a single save only
        set_random_rf();
        for (int i = 0; i < 8; i++) orig_rf[i] = rf[i];
        orig_fl = {f_s, f_n, f_z};
        run_op(1'b1, 1'b1, 1'b1);
        check("both_we_cnt", we_cnt, 9);
        check("both_rf_we_cnt", rfwe_cnt, 0);
        check("both_flag_word", mem[8'hF8], {5'b0, orig_fl});
        check("both_mem_r5", mem[8'hF5], orig_rf[5]);

        // Address wrap with BASE=FC
        clear_stats();
        bus2.start_save = 1'b1;
        tick();
        bus2.start_save = 1'b0;
        repeat (12) tick();
        check("wrap_we_cnt", wr_addr2.size(), 9);
        for (int i = 0; i < 9; i++) begin
            logic [7:0] a;
            a = 8'hFC + 8'(i);
            check($sformatf("wrap_addr_%0d", i), (i < wr_addr2.size()) ? wr_addr2[i] : 8'hxx, a);
        end

        // Reset in the middle of a restore
        for (int i = 0; i < 8; i++) begin
            orig_rf[i] = 8'($urandom);
            img[i]     = 8'($urandom);
            rf[i]      = orig_rf[i];
            mem[8'hF0 + 8'(i)] = img[i];
        end
        img[8]     = 8'($urandom);
        mem[8'hF8] = img[8];
        exp_flags  = img[8][2:0];
        clear_stats();
        bus.start_restore = 1'b1;
        tick();
        bus.start_restore = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_rf_we", bus.rf_writeEnable, 0);
        check("abort_mem_addr", bus.mem_addr, 0);
        check("abort_rf_wdata", bus.rf_dataIn, 0);
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) check($sformatf("abort_rf_%0d", i), rf[i], img[i]);
        for (int i = 4; i < 8; i++) check($sformatf("abort_keep_%0d", i), rf[i], orig_rf[i]);
        check("abort_flags", {f_s, f_n, f_z}, img[8][2:0]);
        run_op(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) check($sformatf("after_abort_rf_%0d", i), rf[i], img[i]);

        // Random round trips; upper flag-word bits are dirtied to show they are ignored
        for (int t = 0; t < 4; t++) begin
            set_random_rf();
            for (int i = 0; i < 8; i++) orig_rf[i] = rf[i];
            orig_fl = {f_s, f_n, f_z};
            run_op(1'b1, 1'b0, 1'b0);
            mem[8'hF8] = mem[8'hF8] | (8'($urandom) & 8'hF8);
            for (int i = 0; i < 8; i++) rf[i] = ~orig_rf[i];
            {f_s, f_n, f_z} = ~orig_fl;
            exp_flags = orig_fl;
            run_op(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < 8; i++) check($sformatf("rt%0d_rf_%0d", t, i), rf[i], orig_rf[i]);
            check($sformatf("rt%0d_flags", t), {f_s, f_n, f_z}, orig_fl);
            check($sformatf("rt%0d_flag_strobes", t), flag_bad, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
